// File: rtl/alu_mode_arbiter.sv
// Arbiter and sequencer for the shared ALU operand path: grants the manual or CPU requester,
// issues one ALU operation and returns its result tagged with the owner. Build option: MODE_LOCK_EN.
module alu_mode_arbiter #(
  parameter int WIDTH    = 8,
  parameter int OPW      = 3,
  parameter int MAX_WAIT = 4,
  parameter int TIMEOUT  = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic             man_valid,
  output logic             man_ready,
  input  logic [WIDTH-1:0] man_a,
  input  logic [WIDTH-1:0] man_b,
  input  logic [OPW-1:0]   man_opcode,
  input  logic             cpu_valid,
  output logic             cpu_ready,
  input  logic [WIDTH-1:0] cpu_a,
  input  logic [WIDTH-1:0] cpu_b,
  input  logic [OPW-1:0]   cpu_opcode,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_opcode,
  output logic             alu_start,
  input  logic             alu_done,
  input  logic [WIDTH-1:0] alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_owner,
  output logic [WIDTH-1:0] rsp_result,
  output logic             active_mode,
  output logic             err_timeout
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam int            TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic [OPW-1:0]   op_q, op_d;
  logic             owner_q, owner_d;
  logic             mode_q, mode_d;
  logic             err_q, err_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             grant_man, grant_cpu;

`ifdef MODE_LOCK_EN
  always_comb begin
    grant_man = (state_q == IDLE) && man_valid && !mode;
    grant_cpu = (state_q == IDLE) && cpu_valid &&  mode;
  end
`else
  localparam int            SW  = $clog2(MAX_WAIT + 1);
  localparam logic [SW-1:0] SAT = SW'(MAX_WAIT);

  logic [SW-1:0] man_cnt_q, man_cnt_d, cpu_cnt_q, cpu_cnt_d;

  // Preference comes from mode in this IDLE cycle: the same value that lands in active_mode.
  always_comb begin
    grant_man = 1'b0;
    grant_cpu = 1'b0;
    man_cnt_d = man_cnt_q;
    cpu_cnt_d = cpu_cnt_q;
    if (state_q == IDLE) begin
      if (man_valid && cpu_valid) begin
        grant_man = mode ? (man_cnt_q == SAT) : (cpu_cnt_q != SAT);
        grant_cpu = !grant_man;
      end else begin
        grant_man = man_valid;
        grant_cpu = cpu_valid;
      end
    end
    if (grant_man) begin
      man_cnt_d = '0;
      if (cpu_valid && cpu_cnt_q != SAT) cpu_cnt_d = cpu_cnt_q + 1'b1;
    end
    if (grant_cpu) begin
      cpu_cnt_d = '0;
      if (man_valid && man_cnt_q != SAT) man_cnt_d = man_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      man_cnt_q <= '0;
      cpu_cnt_q <= '0;
    end else begin
      man_cnt_q <= man_cnt_d;
      cpu_cnt_q <= cpu_cnt_d;
    end
  end
`endif

  // NOTE: every _d gets its hold value first, so no path through the case leaves a latch.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    owner_d  = owner_q;
    result_d = result_q;
    mode_d   = mode_q;
    err_d    = err_q;
    tmo_d    = tmo_q;
    unique case (state_q)
      IDLE: begin
        mode_d = mode;
        if (grant_man || grant_cpu) begin
          a_d     = grant_cpu ? cpu_a      : man_a;
          b_d     = grant_cpu ? cpu_b      : man_b;
          op_d    = grant_cpu ? cpu_opcode : man_opcode;
          owner_d = grant_cpu;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (alu_done) begin
          result_d = alu_result;
          state_d  = RESP;
        end else begin
          tmo_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (alu_done) begin
          result_d = alu_result;
          state_d  = RESP;
        end else if (tmo_q == TMO_LAST) begin
          result_d = '1;
          err_d    = 1'b1;
          state_d  = RESP;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      owner_q  <= 1'b0;
      result_q <= '0;
      mode_q   <= 1'b0;
      err_q    <= 1'b0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      owner_q  <= owner_d;
      result_q <= result_d;
      mode_q   <= mode_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
    end
  end

  assign man_ready   = grant_man;
  assign cpu_ready   = grant_cpu;
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_opcode  = op_q;
  assign alu_start   = (state_q == ISSUE);
  assign rsp_valid   = (state_q == RESP);
  assign rsp_owner   = owner_q;
  assign rsp_result  = result_q;
  assign active_mode = mode_q;
  assign err_timeout = err_q;

endmodule
